// File: rtl/vdcm_ram_pkg.sv
// Shared definitions for the tp_ram two-port memory: controller state
// encoding and read-during-write collision mode constants.
package vdcm_ram_pkg;

    typedef enum logic [0:0] {
        StInit  = 1'b0,
        StReady = 1'b1
    } ctrl_state_e;

    localparam int unsigned RDW_READ_OLD    = 0;
    localparam int unsigned RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/tp_ram_delay.sv
// Valid/data shift pipeline of configurable depth. Data stages only load on a
// valid beat, so the output holds the last delivered word between pulses.
module tp_ram_delay #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= in_data;
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/tp_ram.sv
// Two-port (one write, one read) RAM with per-segment write mask, configurable
// read latency, read-during-write policy and optional zero-fill after reset.
module tp_ram
    import vdcm_ram_pkg::*;
#(
    parameter int unsigned NUMBER_OF_LINES = 8192,
    parameter int unsigned DATA_WIDTH      = 128,
    parameter int unsigned MASK_WIDTH      = 16,
    parameter int unsigned READ_LATENCY    = 1,
    parameter int unsigned RDW_MODE        = 0,
    parameter int unsigned INIT_ON_RESET   = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en,
    input  logic [$clog2(NUMBER_OF_LINES)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic [MASK_WIDTH-1:0]              wr_mask,
    input  logic                               rd_en,
    input  logic [$clog2(NUMBER_OF_LINES)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]              rd_data,
    output logic                               rd_valid,
    output logic                               init_done
);

    localparam int unsigned AW  = $clog2(NUMBER_OF_LINES);
    localparam int unsigned SEG = DATA_WIDTH / MASK_WIDTH;

    ctrl_state_e   state_q, state_d;
    logic [AW-1:0] init_cnt_q, init_cnt_d;

    logic                  in_init;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [MASK_WIDTH-1:0] mem_wmask;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] mem [NUMBER_OF_LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= (INIT_ON_RESET != 0) ? StInit : StReady;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        unique case (state_q)
            StInit: begin
                init_cnt_d = init_cnt_q + AW'(1);
                if (init_cnt_q == AW'(NUMBER_OF_LINES - 1)) begin
                    state_d    = StReady;
                    init_cnt_d = '0;
                end
            end
            StReady: ;
            default: state_d = StInit;
        endcase
    end

    // Gated by rst so a READY reset state never advertises acceptance during reset.
    assign init_done = (state_q == StReady) && !rst;
    assign in_init   = (state_q == StInit) && !rst;
    assign wr_acc    = wr_en && init_done;
    assign rd_acc    = rd_en && init_done;

    always_comb begin
        mem_we    = in_init || wr_acc;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_wmask = wr_mask;
        if (in_init) begin
            mem_waddr = init_cnt_q;
            mem_wdata = '0;
            mem_wmask = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < int'(MASK_WIDTH); i++) begin
                if (mem_wmask[i]) begin
                    mem[mem_waddr][i*SEG +: SEG] <= mem_wdata[i*SEG +: SEG];
                end
            end
        end
    end

    // Write-first forwards the masked segments of a same-cycle write to the same line.
    always_comb begin
        rd_word = mem[rd_addr];
        if (RDW_MODE == RDW_WRITE_FIRST && wr_acc && wr_addr == rd_addr) begin
            for (int i = 0; i < int'(MASK_WIDTH); i++) begin
                if (wr_mask[i]) begin
                    rd_word[i*SEG +: SEG] = wr_data[i*SEG +: SEG];
                end
            end
        end
    end

    tp_ram_delay #(
        .DEPTH (READ_LATENCY),
        .WIDTH (DATA_WIDTH)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_acc),
        .in_data   (rd_word),
        .out_valid (rd_valid),
        .out_data  (rd_data)
    );

endmodule

// File: tb/tb_tp_ram.sv
// Directed bench for tp_ram: two instances (read-old/latency 3, write-first/latency 2)
// share stimulus; an expected-read queue per instance checks timing, data and hold.
module tb_tp_ram;

    localparam int unsigned LINES = 16;
    localparam int unsigned DW    = 32;
    localparam int unsigned MW    = 4;
    localparam int unsigned AW    = 4;
    localparam int          LAT_A = 3;
    localparam int          LAT_B = 2;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          wr_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [MW-1:0] wr_mask = '0;
    logic          rd_en   = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    logic [DW-1:0] a_rd_data, b_rd_data;
    logic          a_rd_valid, b_rd_valid;
    logic          a_init_done, b_init_done;

    tp_ram #(
        .NUMBER_OF_LINES (LINES),
        .DATA_WIDTH      (DW),
        .MASK_WIDTH      (MW),
        .READ_LATENCY    (LAT_A),
        .RDW_MODE        (0),
        .INIT_ON_RESET   (1)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_mask   (wr_mask),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (a_rd_data),
        .rd_valid  (a_rd_valid),
        .init_done (a_init_done)
    );

    tp_ram #(
        .NUMBER_OF_LINES (LINES),
        .DATA_WIDTH      (DW),
        .MASK_WIDTH      (MW),
        .READ_LATENCY    (LAT_B),
        .RDW_MODE        (1),
        .INIT_ON_RESET   (1)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_mask   (wr_mask),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (b_rd_data),
        .rd_valid  (b_rd_valid),
        .init_done (b_init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    exp_t          qa[$];
    exp_t          qb[$];
    logic [DW-1:0] a_last = '0;
    logic [DW-1:0] b_last = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [MW-1:0] m);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_mask = m;
    endtask

    task automatic read(input logic [AW-1:0] a, input logic [DW-1:0] ea,
                        input logic [DW-1:0] eb);
        rd_en   = 1'b1;
        rd_addr = a;
        qa.push_back('{due: cyc + LAT_A, data: ea});
        qb.push_back('{due: cyc + LAT_B, data: eb});
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        qa.delete();
        qb.delete();
        a_last = '0;
        b_last = '0;
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!a_init_done && n < 64) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'd16);
        check({tag, "_b"}, 32'(b_init_done), 32'd1);
    endtask

    // Every cycle: either the expected read lands now, or valid is low and data holds.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (qa.size() != 0 && qa[0].due == cyc) begin
            check("a_valid", 32'(a_rd_valid), 32'd1);
            check("a_data", a_rd_data, qa[0].data);
            void'(qa.pop_front());
        end else begin
            check("a_idle", 32'(a_rd_valid), 32'd0);
            check("a_hold", a_rd_data, a_last);
        end
        a_last = a_rd_data;
        if (qb.size() != 0 && qb[0].due == cyc) begin
            check("b_valid", 32'(b_rd_valid), 32'd1);
            check("b_data", b_rd_data, qb[0].data);
            void'(qb.pop_front());
        end else begin
            check("b_idle", 32'(b_rd_valid), 32'd0);
            check("b_hold", b_rd_data, b_last);
        end
        b_last = b_rd_data;
    end

    initial begin
        tick();
        tick();
        check("rst_init_done_a", 32'(a_init_done), 32'd0);
        check("rst_init_done_b", 32'(b_init_done), 32'd0);
        check("rst_rd_data_a", a_rd_data, 32'h0);
        check("rst_rd_data_b", b_rd_data, 32'h0);

        // Stray requests during INIT must be ignored.
        set_wr(4'd7, 32'hFFFF_FFFF, 4'hF);
        rd_en   = 1'b1;
        rd_addr = 4'd7;
        rst     = 1'b0;
        wait_init("init_cycles");

        // Read in the cycle init_done rises, then sweep all lines.
        wr_en = 1'b0;
        read(4'd7, 32'h0, 32'h0);
        tick();
        for (int i = 0; i < int'(LINES); i++) begin
            read(4'(i), 32'h0, 32'h0);
            tick();
        end
        rd_en = 1'b0;

        // Distinct lines, then back-to-back reads.
        set_wr(4'd0, 32'h1111_1111, 4'hF); tick();
        set_wr(4'd1, 32'h2222_2222, 4'hF); tick();
        set_wr(4'd2, 32'h3333_3333, 4'hF); tick();
        wr_en = 1'b0;
        read(4'd0, 32'h1111_1111, 32'h1111_1111); tick();
        read(4'd1, 32'h2222_2222, 32'h2222_2222); tick();
        read(4'd2, 32'h3333_3333, 32'h3333_3333); tick();
        rd_en = 1'b0;
        repeat (5) tick();

        // Masked writes, including an all-zero mask.
        set_wr(4'd3, 32'hAABB_CCDD, 4'hF); tick();
        set_wr(4'd3, 32'h1122_3344, 4'h5); tick();
        set_wr(4'd3, 32'h0000_0000, 4'h0); tick();
        wr_en = 1'b0;
        read(4'd3, 32'hAA22_CC44, 32'hAA22_CC44); tick();
        rd_en = 1'b0;
        tick();

        // Same-address collisions: full mask, then partial mask.
        set_wr(4'd5, 32'hFFFF_FFFF, 4'hF);
        read(4'd5, 32'h0, 32'hFFFF_FFFF); tick();
        wr_en = 1'b0;
        read(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF); tick();
        set_wr(4'd6, 32'h1234_5678, 4'h3);
        read(4'd6, 32'h0, 32'h0000_5678); tick();
        wr_en = 1'b0;
        read(4'd6, 32'h0000_5678, 32'h0000_5678); tick();

        // Different addresses in the same cycle.
        set_wr(4'd9, 32'hCAFE_BABE, 4'hF);
        read(4'd3, 32'hAA22_CC44, 32'hAA22_CC44); tick();
        wr_en = 1'b0;
        read(4'd9, 32'hCAFE_BABE, 32'hCAFE_BABE); tick();
        rd_en = 1'b0;
        repeat (5) tick();

        // Reset with a read in flight: it must never surface.
        read(4'd0, 32'h1111_1111, 32'h1111_1111);
        tick();
        rd_en = 1'b0;
        do_reset();
        tick();
        check("midrd_init_done_a", 32'(a_init_done), 32'd0);
        check("midrd_rd_data_a", a_rd_data, 32'h0);
        check("midrd_rd_data_b", b_rd_data, 32'h0);
        tick();
        tick();

        // Reset partway through INIT: the fill restarts from line 0.
        rst = 1'b0;
        repeat (5) tick();
        do_reset();
        tick();
        rst = 1'b0;
        wait_init("reinit_cycles");

        read(4'd0, 32'h0, 32'h0); tick();
        read(4'd3, 32'h0, 32'h0); tick();
        read(4'd9, 32'h0, 32'h0); tick();
        rd_en = 1'b0;
        repeat (5) tick();
        check("drain_a", 32'(qa.size()), 32'd0);
        check("drain_b", 32'(qb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
